// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS core: write-back bypass on the
// register-file read data, load-use bubble insertion, branch flush and downstream hold.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [31:0] id_rd_data1,
  input  logic [31:0] id_rd_data2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_dst,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        id_alusrc,
  input  logic [3:0]  id_alu_ctrl,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_dst,
  input  logic [31:0] wb_data,
  input  logic        flush,
  input  logic        ex_hold,
  output logic        stall_id,
  output logic        ex_valid,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic [3:0]  ex_alu_ctrl,
  output logic [4:0]  ex_dst,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [31:0] ex_op_a,
  output logic [31:0] ex_alu_b,
  output logic [31:0] ex_store_data,
  output logic [15:0] stall_cnt,
  output logic [15:0] bubble_cnt
);

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        hazard;
  logic        do_bubble;

  // The register file writes at the same edge it is read, so a matching
  // write-back must be bypassed or the stale value would be captured.
  // NOTE: every always_comb output gets a default first, so no latch can form.
  always_comb begin
    op_a = id_rd_data1;
    op_b = id_rd_data2;
    if (id_rs == 5'd0)                             op_a = '0;
    else if (wb_regwrite && (wb_dst == id_rs))     op_a = wb_data;
    if (id_rt == 5'd0)                             op_b = '0;
    else if (wb_regwrite && (wb_dst == id_rt))     op_b = wb_data;
  end

  assign hazard = id_valid & ex_valid & ex_memread & (ex_dst != 5'd0) &
                  ((id_uses_rs & (ex_dst == id_rs)) | (id_uses_rt & (ex_dst == id_rt)));
  assign stall_id  = ex_hold | (hazard & ~flush);
  assign do_bubble = ~ex_hold & (flush | hazard);

  // NOTE: sequential state uses non-blocking assignments only; reset is
  // synchronous, so it is simply the highest-priority branch of the clocked block.
  always_ff @(posedge clk) begin
    if (rst || (!ex_hold && do_bubble)) begin
      ex_valid      <= 1'b0;
      ex_regwrite   <= 1'b0;
      ex_memread    <= 1'b0;
      ex_memwrite   <= 1'b0;
      ex_alu_ctrl   <= '0;
      ex_dst        <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_op_a       <= '0;
      ex_alu_b      <= '0;
      ex_store_data <= '0;
    end else if (!ex_hold) begin
      ex_valid      <= id_valid;
      ex_regwrite   <= id_regwrite;
      ex_memread    <= id_memread;
      ex_memwrite   <= id_memwrite;
      ex_alu_ctrl   <= id_alu_ctrl;
      ex_dst        <= id_dst;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_op_a       <= op_a;
      ex_alu_b      <= id_alusrc ? id_imm : op_b;
      ex_store_data <= op_b;
    end
  end

  // Event counters saturate so long runs never alias back to small values.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_id && (stall_cnt != 16'hFFFF))   stall_cnt  <= stall_cnt + 16'd1;
      if (do_bubble && (bubble_cnt != 16'hFFFF)) bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic,
// all compared against a behavioural model of the ID/EX register and counters.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [3:0]  alu_ctrl;
    logic [4:0]  dst;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] op_a;
    logic [31:0] alu_b;
    logic [31:0] store_data;
  } ex_t;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_uses_rs, id_uses_rt;
  logic [4:0]  id_rs, id_rt, id_dst, wb_dst;
  logic [31:0] id_rd_data1, id_rd_data2, id_imm, wb_data;
  logic        id_regwrite, id_memread, id_memwrite, id_alusrc, wb_regwrite;
  logic [3:0]  id_alu_ctrl;
  logic        flush, ex_hold;
  logic        stall_id, ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [3:0]  ex_alu_ctrl;
  logic [4:0]  ex_dst, ex_rs, ex_rt;
  logic [31:0] ex_op_a, ex_alu_b, ex_store_data;
  logic [15:0] stall_cnt, bubble_cnt;

  int   vectors = 0;
  int   miscompares = 0;
  ex_t  m_ex;
  int   m_stall_cnt, m_bubble_cnt;
  int   snap;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rd_data1(id_rd_data1), .id_rd_data2(id_rd_data2), .id_imm(id_imm),
    .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_alusrc(id_alusrc), .id_alu_ctrl(id_alu_ctrl),
    .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .wb_data(wb_data),
    .flush(flush), .ex_hold(ex_hold), .stall_id(stall_id),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_alu_ctrl(ex_alu_ctrl), .ex_dst(ex_dst),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_op_a(ex_op_a), .ex_alu_b(ex_alu_b),
    .ex_store_data(ex_store_data), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value an instruction sees for a source register: r0 is zero, a same-cycle
  // write-back wins over the register file's stale read.
  function automatic logic [31:0] src_val(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return 32'd0;
    if (wb_regwrite && wb_dst == idx) return wb_data;
    return rf;
  endfunction

  function automatic bit model_hazard();
    bit reads_load_dst;
    reads_load_dst = (id_uses_rs && id_rs == m_ex.dst) || (id_uses_rt && id_rt == m_ex.dst);
    return id_valid && m_ex.valid && m_ex.memread && m_ex.dst != 0 && reads_load_dst;
  endfunction

  function automatic ex_t dut_ex();
    return '{ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_alu_ctrl, ex_dst,
             ex_rs, ex_rt, ex_op_a, ex_alu_b, ex_store_data};
  endfunction

  // One clock: check stall_id with the settled inputs, advance the model, then
  // check the registered state and counters just after the edge.
  task automatic cycle(input bit do_chk);
    bit   hz, exp_stall;
    ex_t  nxt;
    #1;
    hz        = model_hazard();
    exp_stall = ex_hold || (hz && !flush);
    if (do_chk) chk("stall_id", stall_id, exp_stall);
    nxt = m_ex;
    if (rst) begin
      nxt = '0;
      m_stall_cnt = 0;
      m_bubble_cnt = 0;
    end else begin
      if (exp_stall) m_stall_cnt = (m_stall_cnt < 65535) ? m_stall_cnt + 1 : 65535;
      if (!ex_hold && (flush || hz)) begin
        nxt = '0;
        m_bubble_cnt = (m_bubble_cnt < 65535) ? m_bubble_cnt + 1 : 65535;
      end else if (!ex_hold) begin
        nxt = '{id_valid, id_regwrite, id_memread, id_memwrite, id_alu_ctrl, id_dst,
                id_rs, id_rt, src_val(id_rs, id_rd_data1),
                id_alusrc ? id_imm : src_val(id_rt, id_rd_data2),
                src_val(id_rt, id_rd_data2)};
      end
    end
    @(posedge clk);
    m_ex = nxt;
    #1;
    if (do_chk) begin
      chk("ex_state", dut_ex(), m_ex);
      chk("counters", {stall_cnt, bubble_cnt}, {m_stall_cnt[15:0], m_bubble_cnt[15:0]});
    end
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rs, rt, input logic urs, urt,
                           input logic [31:0] d1, d2, input logic [4:0] dst,
                           input logic rw, mr, mw, as, input logic [3:0] ctrl);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_rd_data1 = d1; id_rd_data2 = d2; id_dst = dst;
    id_regwrite = rw; id_memread = mr; id_memwrite = mw; id_alusrc = as; id_alu_ctrl = ctrl;
  endtask

  task automatic load_lw_r8();
    set_instr(1, 5'd2, 5'd0, 1, 0, 32'h100, 32'h0, 5'd8, 1, 1, 0, 1, 4'd2);
    cycle(1);
  endtask

  initial begin
    rst = 1; flush = 0; ex_hold = 0; id_imm = 32'h40;
    wb_regwrite = 0; wb_dst = 0; wb_data = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    m_ex = '0; m_stall_cnt = 0; m_bubble_cnt = 0;
    @(posedge clk);
    cycle(1);
    rst = 0;

    // Reset then plain load
    set_instr(1, 5'd3, 5'd4, 1, 1, 32'h11, 32'h22, 5'd9, 1, 0, 0, 0, 4'd2);
    cycle(1);
    chk("plain_op_a", ex_op_a, 32'h11);
    chk("plain_alu_b", ex_alu_b, 32'h22);
    chk("plain_valid", ex_valid, 1'b1);

    // Write-back bypass, then r0 never bypassed and always zero
    wb_regwrite = 1; wb_dst = 5'd5; wb_data = 32'hDEADBEEF;
    set_instr(1, 5'd5, 5'd5, 1, 1, 32'h0, 32'h0, 5'd9, 1, 0, 0, 1, 4'd2);
    cycle(1);
    chk("bypass_op_a", ex_op_a, 32'hDEADBEEF);
    chk("bypass_store", ex_store_data, 32'hDEADBEEF);
    chk("bypass_alu_b_imm", ex_alu_b, 32'h40);
    wb_dst = 5'd0;
    set_instr(1, 5'd0, 5'd0, 1, 1, 32'h55, 32'h66, 5'd9, 1, 0, 0, 0, 4'd2);
    cycle(1);
    chk("r0_op_a", ex_op_a, 32'h0);
    wb_regwrite = 0;

    // Load-use: one bubble, then the dependent instruction loads
    rst = 1; cycle(1); rst = 0;
    load_lw_r8();
    set_instr(1, 5'd8, 5'd3, 1, 0, 32'h7, 32'h9, 5'd10, 1, 0, 0, 0, 4'd1);
    #1 chk("lu_stall", stall_id, 1'b1);
    cycle(1);
    chk("lu_bubble", {ex_valid, ex_memread}, 2'b00);
    cycle(1);
    chk("lu_reload", {ex_valid, ex_dst}, {1'b1, 5'd10});
    chk("lu_counts", {stall_cnt, bubble_cnt}, {16'd1, 16'd1});
    load_lw_r8();
    id_uses_rs = 0; id_rs = 5'd8;
    #1 chk("lu_no_use", stall_id, 1'b0);
    cycle(1);

    // Hazard together with flush: bubble, no stall
    load_lw_r8();
    set_instr(1, 5'd8, 5'd3, 1, 0, 32'h7, 32'h9, 5'd10, 1, 0, 0, 0, 4'd1);
    flush = 1;
    snap = bubble_cnt;
    #1 chk("flush_hz_stall", stall_id, 1'b0);
    cycle(1);
    chk("flush_hz_bubble", bubble_cnt, 16'(snap + 1));

    // Hold with flush asserted, then release into a bubble
    flush = 0;
    set_instr(1, 5'd1, 5'd2, 1, 1, 32'hA, 32'hB, 5'd12, 1, 0, 0, 0, 4'd3);
    cycle(1);
    ex_hold = 1; flush = 1;
    snap = stall_cnt;
    set_instr(1, 5'd6, 5'd7, 1, 1, 32'hC, 32'hD, 5'd13, 1, 0, 0, 0, 4'd4);
    repeat (3) cycle(1);
    chk("hold_stall_cnt", stall_cnt, 16'(snap + 3));
    chk("hold_dst", ex_dst, 5'd12);
    ex_hold = 0;
    cycle(1);
    chk("release_bubble", ex_valid, 1'b0);
    flush = 0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 39) == 0);
      flush   = ($urandom_range(0, 7) == 0);
      ex_hold = ($urandom_range(0, 7) == 0);
      wb_regwrite = $urandom_range(0, 1);
      wb_dst  = 5'($urandom_range(0, 5));
      wb_data = $urandom;
      id_imm  = $urandom;
      set_instr($urandom_range(0, 3) != 0, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom,
                5'($urandom_range(0, 5)), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom_range(0, 15)));
      cycle(1);
    end
    rst = 0; flush = 0; ex_hold = 0; wb_regwrite = 0;

    // Counter saturation
    rst = 1; cycle(1); rst = 0;
    ex_hold = 1;
    repeat (70000) cycle(0);
    cycle(1);
    chk("stall_sat", stall_cnt, 16'hFFFF);
    repeat (3) cycle(1);
    chk("stall_sat_hold", stall_cnt, 16'hFFFF);
    ex_hold = 0;

    // Reset during a load-use stall
    load_lw_r8();
    set_instr(1, 5'd8, 5'd3, 1, 0, 32'h7, 32'h9, 5'd10, 1, 0, 0, 0, 4'd1);
    rst = 1;
    cycle(1);
    chk("rst_ex_zero", dut_ex(), ex_t'('0));
    chk("rst_counters", {stall_cnt, bubble_cnt}, 32'h0);
    rst = 0;
    #1 chk("rst_no_stall", stall_id, 1'b0);
    cycle(1);
    chk("rst_reload", {ex_valid, ex_dst}, {1'b1, 5'd10});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage MIPS core. Sits directly downstream of the register file. It captures the register-file read data, immediate and decode controls into the ID/EX register, and applies a write-through bypass for the same-cycle write-back. It also detects load-use hazards, inserting a bubble and stalling IF/ID, and handles branch flush and downstream hold.

## Interface
- No parameters; data width fixed at 32, register index width at 5.
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  5  source indices (same values driving register-file ReadReg1/ReadReg2).
- id_uses_rs, id_uses_rt  in  1  instruction actually reads rs/rt.
- id_rd_data1, id_rd_data2  in  32  register-file ReadData1/ReadData2.
- id_imm  in  32  sign-extended immediate.
- id_dst  in  5; id_regwrite, id_memread, id_memwrite, id_alusrc  in  1; id_alu_ctrl  in  4  decode controls.
- wb_regwrite  in  1; wb_dst  in  5; wb_data  in  32  write-back bus (same signals as register-file RegWrite/WriteReg/WriteData).
- flush  in  1  branch taken in EX; kill the ID instruction.
- ex_hold  in  1  EX and later stages frozen.
- stall_id  out  1  freeze PC and IF/ID (combinational).
- ex_valid, ex_regwrite, ex_memread, ex_memwrite  out  1; ex_alu_ctrl  out  4; ex_dst, ex_rs, ex_rt  out  5  registered controls.
- ex_op_a, ex_alu_b, ex_store_data  out  32  registered operands.
- stall_cnt, bubble_cnt  out  16  saturating event counters.

## Operation
- Bypass:
  - op_a = wb_dst==id_rs && wb_regwrite && wb_dst!=0 ? wb_data : id_rd_data1.
  - op_b is the same with rt and id_rd_data2.
  - Index 0 always yields 0.
- hazard = id_valid & ex_valid & ex_memread & ex_dst!=0 & ((id_uses_rs & ex_dst==id_rs) | (id_uses_rt & ex_dst==id_rt)).
- stall_id = ex_hold | (hazard & ~flush).
- The ID/EX register update has three actions:
  - Load: all ex_* take ID values. ex_valid=id_valid, ex_alu_b = id_alusrc ? id_imm : op_b, ex_store_data = op_b.
  - Bubble: ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_alu_ctrl, ex_dst all 0. Data and index outputs are don't-care; they are driven 0.
  - Hold: no change.
- Per-cycle priority:
  1. rst: all outputs 0, counters 0.
  2. ex_hold: hold. flush is ignored; the source keeps flush asserted until hold drops.
  3. flush: bubble.
  4. hazard: bubble.
  5. Otherwise: load.
- Counters:
  - stall_cnt increments each cycle stall_id=1.
  - bubble_cnt increments each cycle a bubble is written.
  - Both saturate at 16'hFFFF and do not wrap.
  - Neither increments during rst.
- Forwarding from EX/MEM and MEM/WB into EX belongs to the EX forwarding unit, not this block. ex_rs/ex_rt are exported for it.
- When ex_hold=1, MEM and WB are frozen as well, so wb_* cannot change the held operands' validity.

## Timing
- One-cycle latency: ID inputs sampled at posedge N appear on ex_* after posedge N.
- stall_id is combinational from the current ex_* registers and id_* inputs; same-cycle, no registered delay.
- Load-use costs exactly one bubble. The cycle after the bubble, hazard is 0 because ex_memread=0 and the instruction loads.
- Same-cycle write-back and read of the same index captures wb_data, never the stale register-file value.
- Reset mid-stall: the next cycle has all outputs 0, stall_id reflects only ex_hold, and the ID instruction is reloaded normally.
- Simultaneous flush and hazard: bubble, stall_id=0, and bubble_cnt increments once.

## Test plan
- Reset then plain load:
  - Stimulus: rst 1 cycle, then id_valid=1, rs=3 (data1=0x11), rt=4 (data2=0x22), alusrc=0, alu_ctrl=2.
  - Required: next cycle ex_op_a=0x11, ex_alu_b=0x22, ex_valid=1, stall_id=0.
- WB bypass:
  - Stimulus: wb_regwrite=1, wb_dst=5, wb_data=0xDEADBEEF, with id_rs=5 and stale id_rd_data1=0.
  - Required: ex_op_a=0xDEADBEEF.
  - Repeat with wb_dst=0 and id_rs=0: ex_op_a=0.
- Load-use:
  - Stimulus: lw to r8 loaded into ID/EX, next ID instruction has rs=8 and uses_rs=1.
  - Required: stall_id=1 for one cycle; next ex_valid=0 and ex_memread=0; following cycle the instruction loads; stall_cnt=1, bubble_cnt=1.
  - Same case with uses_rs=0: no stall.
- Flush vs hazard vs hold:
  - Hazard + flush: bubble, stall_id=0.
  - ex_hold=1 for 3 cycles with flush=1: ex_* unchanged, stall_id=1, stall_cnt +3.
  - Release hold with flush still 1: bubble.
- Counter saturation: force 70000 stall cycles -> stall_cnt=16'hFFFF and stays there.
- Reset mid-stall: assert rst during a load-use stall -> all ex_* = 0, counters = 0, stall_id=0 next cycle.
